hazard_ctrl_unit: RTL and testbench

HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

---
 rtl/hazard_pkg.sv | 18 +
 rtl/sat_counter.sv | 37 +++
 rtl/hazard_ctrl_unit.sv | 138 +++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard control unit: FSM state encoding and
// the default parameter values used by the top level.
package hazard_pkg;

    localparam int DEF_REG_AW  = 5;
    localparam int DEF_MEM_LAT = 2;
    localparam int DEF_CNT_W   = 16;

    // Width of the memory-latency down-counter; MEM_LAT is limited to 0..15.
    localparam int LAT_CW      = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RELEASE = 2'd2
    } hz_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low
// reset. Clear wins over a same-cycle increment; the count sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear first, then increment unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard control: load-use stall, taken-branch flush and a
// data-memory freeze of MEM_LAT cycles per access. All control outputs are
// combinational; only the stall counter and the freeze FSM hold state.
//
// Handshake: memReq is a level qualifier sampled in IDLE only; the access
// is held off (pipeline frozen) for exactly MEM_LAT cycles starting in the
// cycle memReq is seen, followed by one RELEASE cycle in which memReq is
// ignored so the completing instruction can advance.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW  = DEF_REG_AW,
    parameter int MEM_LAT = DEF_MEM_LAT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] idRs,
    input  logic [REG_AW-1:0] idRt,
    input  logic              idUsesRs,
    input  logic              idUsesRt,
    input  logic              exMemRead,
    input  logic [REG_AW-1:0] exRt,
    input  logic              branchTaken,
    input  logic              memReq,
    input  logic              cntClr,
    output logic              PCWrite,
    output logic              IFIDWrite,
    output logic              IDEXWrite,
    output logic              EXMEMWrite,
    output logic              setZero,
    output logic              ifidFlush,
    output logic              memBusy,
    output logic [CNT_W-1:0]  stallCount,
    output logic [1:0]        dbgState
);

    // A zero-latency memory never freezes the pipeline.
    localparam bit              LAT_EN   = (MEM_LAT > 0);
    localparam int              LAT_M1   = LAT_EN ? (MEM_LAT - 1) : 0;
    localparam logic [LAT_CW-1:0] LAT_LOAD = LAT_CW'(LAT_M1);

    hz_state_e          state_q;
    hz_state_e          state_d;
    logic [LAT_CW-1:0]  cnt_q;
    logic [LAT_CW-1:0]  cnt_d;
    logic               freeze;
    logic               load_use;

    // Freeze FSM state and latency counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Freeze FSM next state. The IDLE cycle that sees memReq is itself the
    // first frozen cycle, so only MEM_LAT-1 further cycles are spent in WAIT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (memReq && LAT_EN) begin
                    cnt_d   = LAT_LOAD;
                    state_d = (LAT_LOAD != '0) ? ST_WAIT : ST_RELEASE;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= LAT_CW'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d   = cnt_q - LAT_CW'(1);
                end
            end
            ST_RELEASE: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Hazard detection; register 0 is hard-wired so it never creates a hazard.
    always_comb begin
        freeze   = ((state_q == ST_IDLE) && memReq && LAT_EN) ||
                   (state_q == ST_WAIT);
        load_use = exMemRead && (exRt != '0) &&
                   ((idUsesRs && (idRs == exRt)) ||
                    (idUsesRt && (idRt == exRt)));
    end

    // Pipeline control priority: freeze, then load-use, then taken branch.
    // A branch coinciding with a load-use stall is not flushed here; it
    // re-resolves in ID on the following cycle.
    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IDEXWrite  = 1'b1;
        EXMEMWrite = 1'b1;
        setZero    = 1'b0;
        ifidFlush  = 1'b0;
        memBusy    = freeze;
        if (freeze) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXWrite  = 1'b0;
            EXMEMWrite = 1'b0;
        end else if (load_use) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            setZero    = 1'b1;
        end else if (branchTaken) begin
            ifidFlush  = 1'b1;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cntClr),
        .inc (~PCWrite),
        .q   (stallCount)
    );

    assign dbgState = state_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: a vector table for the combinational
// priority logic plus hand-written sequences for freeze, reset and the
// saturating stall counter.
module tb_hazard_ctrl_unit;

    logic       clk;
    logic       rst;
    logic       rst4;
    logic [4:0] idRs, idRt, exRt;
    logic       idUsesRs, idUsesRt, exMemRead, branchTaken;
    logic       memReq, memReq4, cntClr;

    logic       PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, setZero, ifidFlush, memBusy;
    logic [3:0] stallCount;
    logic [1:0] dbgState;

    logic       PCWrite0, IFIDWrite0, IDEXWrite0, EXMEMWrite0, setZero0, ifidFlush0, memBusy0;
    logic [15:0] stallCount0;
    logic [1:0]  dbgState0;

    logic       PCWrite4, IFIDWrite4, IDEXWrite4, EXMEMWrite4, setZero4, ifidFlush4, memBusy4;
    logic [15:0] stallCount4;
    logic [1:0]  dbgState4;

    int n_checks;
    int n_fail;
    int exp_cnt;

    // Clock and initial reset.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    hazard_ctrl_unit #(.REG_AW(5), .MEM_LAT(3), .CNT_W(4)) u_dut (
        .clk(clk), .rst(rst), .idRs(idRs), .idRt(idRt), .idUsesRs(idUsesRs),
        .idUsesRt(idUsesRt), .exMemRead(exMemRead), .exRt(exRt),
        .branchTaken(branchTaken), .memReq(memReq), .cntClr(cntClr),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite),
        .EXMEMWrite(EXMEMWrite), .setZero(setZero), .ifidFlush(ifidFlush),
        .memBusy(memBusy), .stallCount(stallCount), .dbgState(dbgState)
    );

    hazard_ctrl_unit #(.REG_AW(5), .MEM_LAT(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .idRs(idRs), .idRt(idRt), .idUsesRs(idUsesRs),
        .idUsesRt(idUsesRt), .exMemRead(exMemRead), .exRt(exRt),
        .branchTaken(branchTaken), .memReq(memReq), .cntClr(cntClr),
        .PCWrite(PCWrite0), .IFIDWrite(IFIDWrite0), .IDEXWrite(IDEXWrite0),
        .EXMEMWrite(EXMEMWrite0), .setZero(setZero0), .ifidFlush(ifidFlush0),
        .memBusy(memBusy0), .stallCount(stallCount0), .dbgState(dbgState0)
    );

    hazard_ctrl_unit #(.REG_AW(5), .MEM_LAT(4), .CNT_W(16)) u_dut4 (
        .clk(clk), .rst(rst4), .idRs(idRs), .idRt(idRt), .idUsesRs(idUsesRs),
        .idUsesRt(idUsesRt), .exMemRead(exMemRead), .exRt(exRt),
        .branchTaken(branchTaken), .memReq(memReq4), .cntClr(cntClr),
        .PCWrite(PCWrite4), .IFIDWrite(IFIDWrite4), .IDEXWrite(IDEXWrite4),
        .EXMEMWrite(EXMEMWrite4), .setZero(setZero4), .ifidFlush(ifidFlush4),
        .memBusy(memBusy4), .stallCount(stallCount4), .dbgState(dbgState4)
    );

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       exmr;
        logic [4:0] ext;
        logic       br;
        logic [5:0] exp;   // {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, setZero, ifidFlush}
    } vec_t;

    vec_t vec[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic quiet_inputs();
        idRs = 5'd0; idRt = 5'd0; idUsesRs = 1'b0; idUsesRt = 1'b0;
        exMemRead = 1'b0; exRt = 5'd0; branchTaken = 1'b0;
        memReq = 1'b0; memReq4 = 1'b0; cntClr = 1'b0;
    endtask

    task automatic drive_vec(input vec_t v);
        idRs = v.rs; idRt = v.rt; idUsesRs = v.urs; idUsesRt = v.urt;
        exMemRead = v.exmr; exRt = v.ext; branchTaken = v.br;
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat_inc(input int c);
        return (c == 15) ? 15 : c + 1;
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_cnt  = 0;

        //           rs     rt     urs   urt   exmr  ext    br    expected
        vec[0]  = '{5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 6'b111100};
        vec[1]  = '{5'd8, 5'd3, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 6'b001110};
        vec[2]  = '{5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 6'b111100};
        vec[3]  = '{5'd4, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 6'b001110};
        vec[4]  = '{5'd4, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 6'b111100};
        vec[5]  = '{5'd9, 5'd4, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 6'b111100};
        vec[6]  = '{5'd8, 5'd3, 1'b1, 1'b1, 1'b0, 5'd8, 1'b0, 6'b111100};
        vec[7]  = '{5'd8, 5'd3, 1'b1, 1'b1, 1'b1, 5'd8, 1'b1, 6'b001110};
        vec[8]  = '{5'd8, 5'd3, 1'b1, 1'b1, 1'b0, 5'd8, 1'b1, 6'b111101};
        vec[9]  = '{5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 6'b001110};
        vec[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 6'b111101};

        quiet_inputs();
        rst  = 1'b0;
        rst4 = 1'b0;
        #12;
        rst  = 1'b1;
        rst4 = 1'b1;
        step();

        // Reset state.
        check("reset_enables", 32'({PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, setZero, ifidFlush}), 32'(6'b111100));
        check("reset_membusy", 32'(memBusy), 32'd0);
        check("reset_count", 32'(stallCount), 32'd0);
        check("reset_state", 32'(dbgState), 32'd0);

        // Combinational priority table; stall counter tracked alongside.
        for (int i = 0; i < 11; i++) begin
            drive_vec(vec[i]);
            @(negedge clk);
            check($sformatf("vec%0d_ctrl", i),
                  32'({PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, setZero, ifidFlush}),
                  32'(vec[i].exp));
            step();
            if (vec[i].exp[5] == 1'b0) exp_cnt = sat_inc(exp_cnt);
            check($sformatf("vec%0d_count", i), 32'(stallCount), 32'(exp_cnt));
        end
        quiet_inputs();

        // Clear counter, then one memory access with MEM_LAT=3.
        cntClr = 1'b1;
        step();
        cntClr = 1'b0;
        exp_cnt = 0;
        check("clr_count", 32'(stallCount), 32'(exp_cnt));

        memReq = 1'b1;
        @(negedge clk);
        check("mem_c0_ctrl", 32'({PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, setZero, ifidFlush}), 32'(6'b000000));
        check("mem_c0_busy", 32'(memBusy), 32'd1);
        check("lat0_busy", 32'(memBusy0), 32'd0);
        check("lat0_pcw", 32'(PCWrite0), 32'd1);
        step();
        exp_cnt = sat_inc(exp_cnt);
        memReq = 1'b0;
        // Load-use and branch during freeze must be overridden.
        drive_vec(vec[7]);
        @(negedge clk);
        check("mem_c1_ctrl", 32'({PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, setZero, ifidFlush}), 32'(6'b000000));
        check("mem_c1_busy", 32'(memBusy), 32'd1);
        step();
        exp_cnt = sat_inc(exp_cnt);
        quiet_inputs();
        @(negedge clk);
        check("mem_c2_ctrl", 32'({PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, setZero, ifidFlush}), 32'(6'b000000));
        check("mem_c2_busy", 32'(memBusy), 32'd1);
        step();
        exp_cnt = sat_inc(exp_cnt);
        // RELEASE cycle ignores a new request.
        memReq = 1'b1;
        @(negedge clk);
        check("mem_rel_ctrl", 32'({PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, setZero, ifidFlush}), 32'(6'b111100));
        check("mem_rel_busy", 32'(memBusy), 32'd0);
        check("mem_rel_state", 32'(dbgState), 32'd2);
        step();
        memReq = 1'b0;
        check("mem_count", 32'(stallCount), 32'(exp_cnt));
        check("mem_idle_state", 32'(dbgState), 32'd0);

        // Saturation with CNT_W=4, then clear against a concurrent stall.
        drive_vec(vec[1]);
        for (int i = 0; i < 20; i++) begin
            step();
            exp_cnt = sat_inc(exp_cnt);
        end
        check("sat_count", 32'(stallCount), 32'd15);
        check("sat_model", 32'(stallCount), 32'(exp_cnt));
        cntClr = 1'b1;
        step();
        exp_cnt = 0;
        check("clr_vs_inc", 32'(stallCount), 32'(exp_cnt));
        quiet_inputs();

        // Reset in the second WAIT cycle with MEM_LAT=4.
        memReq4 = 1'b1;
        @(negedge clk);
        check("r4_c0_busy", 32'(memBusy4), 32'd1);
        step();
        memReq4 = 1'b0;
        @(negedge clk);
        check("r4_wait1_busy", 32'(memBusy4), 32'd1);
        step();
        @(negedge clk);
        check("r4_wait2_busy", 32'(memBusy4), 32'd1);
        check("r4_wait2_count", 32'(stallCount4), 32'd2);
        rst4 = 1'b0;
        #1;
        check("r4_rst_busy", 32'(memBusy4), 32'd0);
        check("r4_rst_pcw", 32'(PCWrite4), 32'd1);
        check("r4_rst_count", 32'(stallCount4), 32'd0);
        check("r4_rst_state", 32'(dbgState4), 32'd0);
        #1;
        rst4 = 1'b1;
        step();

        // First access after reset gets the full four-cycle freeze.
        for (int k = 0; k < 5; k++) begin
            memReq4 = (k == 0);
            @(negedge clk);
            check($sformatf("r4_post_c%0d_busy", k), 32'(memBusy4), (k < 4) ? 32'd1 : 32'd0);
            check($sformatf("r4_post_c%0d_pcw", k), 32'(PCWrite4), (k < 4) ? 32'd0 : 32'd1);
            step();
        end
        check("r4_post_count", 32'(stallCount4), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
